// File: rtl/comb_mac4.sv
// comb_mac4: four-neuron signed multiply-accumulate over a NUM_FEAT-element feature vector.
// Optional COMB_MAC_BIAS_EN adds per-neuron bias ports b4..b7 that preload the accumulators on start.
module comb_mac4 #(
    parameter int NUM_FEAT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  x,
    input  logic [7:0]  w4,
    input  logic [7:0]  w5,
    input  logic [7:0]  w6,
    input  logic [7:0]  w7,
`ifdef COMB_MAC_BIAS_EN
    input  logic [12:0] b4,
    input  logic [12:0] b5,
    input  logic [12:0] b6,
    input  logic [12:0] b7,
`endif
    output logic [20:0] y4,
    output logic [20:0] y5,
    output logic [20:0] y6,
    output logic [20:0] y7,
    output logic        y_valid,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t      state, next;
    logic [7:0]  cnt;
    logic [20:0] acc4, acc5, acc6, acc7;
    logic        beat, last;

    function automatic logic [20:0] mac(input logic [20:0] a, input logic [7:0] xv, input logic [7:0] wv);
        logic [15:0] p;
        p = 16'($signed(xv) * $signed(wv));
        return a + {{5{p[15]}}, p};
    endfunction

    assign in_ready = state == ACCUM;
    assign busy     = state != IDLE;
    assign beat     = in_ready && in_valid;
    assign last     = cnt == 8'(NUM_FEAT - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        if (state == IDLE)       next = start ? ACCUM : IDLE;
        else if (state == ACCUM) next = (beat && last) ? DONE : ACCUM;
        else                     next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc4    <= '0;
            acc5    <= '0;
            acc6    <= '0;
            acc7    <= '0;
            y4      <= '0;
            y5      <= '0;
            y6      <= '0;
            y7      <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= state == DONE;
            if (state == IDLE && start) begin
                cnt  <= '0;
`ifdef COMB_MAC_BIAS_EN
                acc4 <= {{8{b4[12]}}, b4};
                acc5 <= {{8{b5[12]}}, b5};
                acc6 <= {{8{b6[12]}}, b6};
                acc7 <= {{8{b7[12]}}, b7};
`else
                acc4 <= '0;
                acc5 <= '0;
                acc6 <= '0;
                acc7 <= '0;
`endif
            end else if (beat) begin
                cnt  <= cnt + 8'd1;
                acc4 <= mac(acc4, x, w4);
                acc5 <= mac(acc5, x, w5);
                acc6 <= mac(acc6, x, w6);
                acc7 <= mac(acc7, x, w7);
            end
            // Results move only here, so the downstream stage sees stable values between pulses.
            if (state == DONE) begin
                y4 <= acc4;
                y5 <= acc5;
                y6 <= acc6;
                y7 <= acc7;
            end
        end
    end
endmodule

// File: tb/tb_comb_mac4.sv
// tb_comb_mac4: randomized and directed checks of comb_mac4 against an arithmetic dot-product model.
// Three instances cover NUM_FEAT = 4, 64 and 1.
module tb_comb_mac4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  start = '0;
    logic [7:0]  x = '0, w4 = '0, w5 = '0, w6 = '0, w7 = '0;
    logic [12:0] b4 = '0, b5 = '0, b6 = '0, b7 = '0;
    logic [2:0]  in_ready, y_valid, busy;
    logic [20:0] y4 [3];
    logic [20:0] y5 [3];
    logic [20:0] y6 [3];
    logic [20:0] y7 [3];
    int checks = 0;
    int fails = 0;
    int vx [256];
    int vw [256][4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        comb_mac4 #(.NUM_FEAT(g == 0 ? 4 : g == 1 ? 64 : 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .in_valid(in_valid), .in_ready(in_ready[g]),
            .x(x), .w4(w4), .w5(w5), .w6(w6), .w7(w7),
`ifdef COMB_MAC_BIAS_EN
            .b4(b4), .b5(b5), .b6(b6), .b7(b7),
`endif
            .y4(y4[g]), .y5(y5[g]), .y6(y6[g]), .y7(y7[g]), .y_valid(y_valid[g]), .busy(busy[g])
        );
    end

    function automatic int nf(input int d);
        return d == 0 ? 4 : d == 1 ? 64 : 1;
    endfunction

    function automatic int bias_of(input int k);
`ifdef COMB_MAC_BIAS_EN
        return k == 0 ? int'($signed(b4)) : k == 1 ? int'($signed(b5)) : k == 2 ? int'($signed(b6)) : int'($signed(b7));
`else
        return 0;
`endif
    endfunction

    function automatic logic [20:0] yk(input int d, input int k);
        return k == 0 ? y4[d] : k == 1 ? y5[d] : k == 2 ? y6[d] : y7[d];
    endfunction

    // Start a vector on instance d, stream vx/vw, and check the DONE/result/idle cycles.
    task automatic run_vec(input int d, input bit stall, input bit poke_start, input string name);
        int n, i, cyc;
        int e [4];
        logic [20:0] ex [4];
        n = nf(d);
        for (int k = 0; k < 4; k++) begin
            e[k] = bias_of(k);
            for (int j = 0; j < n; j++) e[k] += vx[j] * vw[j][k];
            ex[k] = 21'(e[k]);
        end
        @(negedge clk); start[d] = 1'b1;
        @(negedge clk); start[d] = 1'b0;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 4 * n + 8) begin
            in_valid = stall ? (cyc % 2 == 0) : 1'b1;
            x  = 8'(vx[i]);
            w4 = 8'(vw[i][0]);
            w5 = 8'(vw[i][1]);
            w6 = 8'(vw[i][2]);
            w7 = 8'(vw[i][3]);
            start[d] = poke_start && (cyc % 3 == 1);
            checks++;
            if (in_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL %s in_ready_accum d=%0d cyc=%0d got=%b want=1", name, d, cyc, in_ready[d]);
            end
            if (in_valid && in_ready[d]) i++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start[d] = 1'b0;
        checks++;
        if (i < n) begin
            fails++;
            $display("FAIL %s beat_budget d=%0d accepted=%0d want=%0d", name, d, i, n);
            return;
        end
        checks++;
        if ({in_ready[d], busy[d], y_valid[d]} !== 3'b010) begin
            fails++;
            $display("FAIL %s done_state d=%0d got ready,busy,yv=%b want=010", name, d, {in_ready[d], busy[d], y_valid[d]});
        end
        @(negedge clk);
        checks++;
        if (y_valid[d] !== 1'b1) begin
            fails++;
            $display("FAIL %s y_valid_pulse d=%0d got=%b want=1", name, d, y_valid[d]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (yk(d, k) !== ex[k]) begin
                fails++;
                $display("FAIL %s y%0d d=%0d got=%0d want=%0d", name, k + 4, d, $signed(yk(d, k)), $signed(ex[k]));
            end
        end
        @(negedge clk);
        checks++;
        if ({y_valid[d], busy[d]} !== 2'b00 || yk(d, 0) !== ex[0]) begin
            fails++;
            $display("FAIL %s after_pulse d=%0d got yv,busy=%b y4=%0d want 00 y4=%0d", name, d, {y_valid[d], busy[d]}, $signed(yk(d, 0)), $signed(ex[0]));
        end
    endtask

    task automatic load_first;
        for (int i = 0; i < 4; i++) begin
            vx[i] = i + 1;
            vw[i][0] = 1; vw[i][1] = -1; vw[i][2] = 0; vw[i][3] = 2;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({in_ready[d], busy[d], y_valid[d]} !== 3'b000 || y4[d] !== 21'd0 || y7[d] !== 21'd0) begin
                fails++;
                $display("FAIL reset d=%0d got ready,busy,yv=%b y4=%0d y7=%0d want 000 0 0", d, {in_ready[d], busy[d], y_valid[d]}, y4[d], y7[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        b4 = '0; b5 = '0; b6 = '0; b7 = '0;
        load_first();
        run_vec(0, 1'b0, 1'b0, "basic");
    endtask

    task automatic test_bias;
        b4 = -13'sd5;
        load_first();
        run_vec(0, 1'b0, 1'b0, "bias");
        b4 = '0;
    endtask

    task automatic test_stall;
        for (int i = 0; i < 4; i++) begin
            vx[i] = 127;
            vw[i][0] = 0; vw[i][1] = 0; vw[i][2] = 127; vw[i][3] = 0;
        end
        run_vec(0, 1'b1, 1'b0, "stall");
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 64; i++) begin
            vx[i] = -128;
            vw[i][0] = -128; vw[i][1] = 3; vw[i][2] = -1; vw[i][3] = 0;
        end
        run_vec(1, 1'b0, 1'b0, "wrap");
    endtask

    task automatic test_abort;
        @(negedge clk); start[0] = 1'b1;
        @(negedge clk); start[0] = 1'b0;
        in_valid = 1'b1; x = 8'd9; w4 = 8'd9; w5 = 8'd9; w6 = 8'd9; w7 = 8'd9;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (y_valid[0] !== 1'b0 || busy[0] !== 1'b0 || y4[0] !== 21'd0) begin
                fails++;
                $display("FAIL abort_quiet cyc=%0d got yv=%b busy=%b y4=%0d want 0 0 0", c, y_valid[0], busy[0], y4[0]);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            vx[i] = 1;
            vw[i][0] = 1; vw[i][1] = 0; vw[i][2] = 0; vw[i][3] = 0;
        end
        run_vec(0, 1'b0, 1'b0, "abort_restart");
    endtask

    task automatic test_ignore;
        in_valid = 1'b1;
        x = 8'd50; w4 = 8'd50; w5 = 8'd50; w6 = 8'd50; w7 = 8'd50;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (in_ready[0] !== 1'b0 || busy[0] !== 1'b0) begin
                fails++;
                $display("FAIL idle_ignore got ready=%b busy=%b want 0 0", in_ready[0], busy[0]);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vx[i] = $urandom_range(255) - 128;
            for (int k = 0; k < 4; k++) vw[i][k] = $urandom_range(255) - 128;
        end
        run_vec(0, 1'b1, 1'b1, "start_ignore");
    endtask

    task automatic test_random;
        for (int r = 0; r < 9; r++) begin
            int d;
            d = r % 3;
            b4 = 13'($urandom); b5 = 13'($urandom); b6 = 13'($urandom); b7 = 13'($urandom);
            for (int i = 0; i < nf(d); i++) begin
                vx[i] = $urandom_range(255) - 128;
                for (int k = 0; k < 4; k++) vw[i][k] = $urandom_range(255) - 128;
            end
            run_vec(d, 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bias();
        test_stall();
        test_wrap();
        test_abort();
        test_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/comb_mac4.md
# comb_mac4

Combination-stage multiply-accumulate for four output neurons of the GNN layer. It streams an aggregated feature vector with one weight per neuron per element and accumulates four signed dot products. It then presents them as 21-bit signed results y4..y7 with a one-cycle valid pulse. It sits directly upstream of the ReLU stage, which samples y4..y7 every clock and truncates them to 13 bits.

## Interface
- NUM_FEAT, 16, number of feature elements per vector; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a new vector; sampled only in IDLE.
- in_valid  in  1  x/w4..w7 beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- x  in  8  signed feature element.
- w4, w5, w6, w7  in  8 each  signed weights for neurons 4..7.
- b4, b5, b6, b7  in  13 each  signed biases, sampled on start; present only with COMB_MAC_BIAS_EN.
- y4, y5, y6, y7  out  21 each  signed results, held until the next result.
- y_valid  out  1  one-cycle pulse when y4..y7 update.
- busy  out  1  high in ACCUM and DONE.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- **IDLE**
  - in_ready=0; in_valid is ignored.
  - start=1: clear the element counter and acc4..acc7 (see Configuration), then go to ACCUM.
- **ACCUM**
  - in_ready=1.
  - Per accepted beat: acc_k <= acc_k + x*w_k for k=4..7, and the counter increments.
  - The beat accepted with counter == NUM_FEAT-1 moves the FSM to DONE.
  - in_valid=0 stalls with no state change.
  - start is ignored.
- **DONE**
  - in_ready=0.
  - Next edge: y_k <= acc_k, y_valid=1 for exactly one cycle, return to IDLE.
- **Arithmetic**
  - The 8x8 signed product is 16-bit signed.
  - Each product is sign-extended to 21 bits.
  - Accumulation wraps modulo 2^21 with no saturation and no overflow flag.
- y4..y7 change only on the y_valid cycle; between results they are stable.
- Reset values:
  - state=IDLE, counter=0, acc=0.
  - y4..y7=0, y_valid=0, in_ready=0, busy=0.
- Asynchronous reset mid-ACCUM discards the partial sums; no y_valid follows.

## Timing
- Throughput: one beat per clock while in_valid=1.
- start accepted at edge T: in_ready is high from the cycle after T.
- Last beat accepted at edge L: state=DONE during the cycle after L; y_valid high during the cycle after edge L+1.
- Minimum start-to-start period is NUM_FEAT+2 cycles. start may be asserted in the same cycle y_valid is high, because the FSM is in IDLE then.
- With NUM_FEAT=1, a single beat moves the FSM directly to DONE.
- in_ready is a registered function of state only, with no combinational path from in_valid.
- The ReLU stage registers y4..y7 on every edge, so its captured value is correct from the edge after y_valid onward.

## Configuration
- Macro: COMB_MAC_BIAS_EN.
- **Defined:**
  - Ports b4..b7 exist.
  - On an accepted start, acc_k <= sign-extended b_k.
- **Undefined:**
  - Ports b4..b7 are absent.
  - On an accepted start, acc_k <= 0.
- All other behaviour is identical in both builds.

## Test plan
- Reset with NUM_FEAT=4, then start. Stream x=1,2,3,4 with w4=1, w5=-1, w6=0, w7=2 -> y4=10, y5=-10, y6=0, y7=20. y_valid is high for exactly one cycle, 2 edges after the last beat.
- NUM_FEAT=4: x=127, w6=127 for all beats, with in_valid toggling 1,0,1,0,... -> y6=64516. Stalls do not corrupt the sum, and in_ready stays 1 throughout ACCUM.
- NUM_FEAT=64: x=-128, w4=-128 every beat -> y4=-1048576, showing wrap of 2^20.
- Assert rst_n=0 after 2 of 4 beats, then start a fresh vector of all-ones x and w4 -> y4=4. No y_valid occurs for the aborted vector, and y4..y7=0 before the new result.
- Pulse start during ACCUM and drive in_valid=1 in IDLE -> both are ignored; the count and sums are unaffected.
- With COMB_MAC_BIAS_EN defined: b4=-5, and the vector from the first test -> y4=5. Without the macro the same stimulus gives y4=10.
